// File: rtl/sqrt_pipe.sv
// sqrt_pipe: fully pipelined restoring integer square root.
// Each stage resolves one root bit from two radicand bits. All stages
// advance together under a single global stall (adv).

// One restoring root-bit step. Purely combinational; registers live in the top.
module sqrt_stage #(
  parameter int RAD_W  = 10,
  parameter int ROOT_W = RAD_W / 2
) (
  input  logic [ROOT_W-1:0] i_root,
  input  logic [ROOT_W+1:0] i_rem,
  input  logic [RAD_W-1:0]  i_rad,
  output logic [ROOT_W-1:0] o_root,
  output logic [ROOT_W+1:0] o_rem,
  output logic [RAD_W-1:0]  o_rad
);
  logic [ROOT_W+1:0] w_shift;
  logic [ROOT_W+1:0] w_trial;
  logic [ROOT_W+1:0] w_diff;
  logic              w_ge;
  logic              w_unused;

  // Incoming remainder is <= 2*root < 2^ROOT_W, so its top two bits are
  // always zero and shifting them out loses nothing.
  assign w_shift  = {i_rem[ROOT_W-1:0], i_rad[RAD_W-1 -: 2]};
  assign w_trial  = {i_root, 2'b01};
  assign w_ge     = (w_shift >= w_trial);
  assign w_diff   = w_shift - w_trial;
  assign o_rem    = w_ge ? w_diff : w_shift;
  assign o_root   = {i_root[ROOT_W-2:0], w_ge};
  assign o_rad    = {i_rad[RAD_W-3:0], 2'b00};
  assign w_unused = &{1'b0, i_rem[ROOT_W+1:ROOT_W]};
endmodule

module sqrt_pipe #(
  parameter  int RAD_W  = 10,
  localparam int ROOT_W = RAD_W / 2,
  localparam int CNT_W  = $clog2(ROOT_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [RAD_W-1:0]  i_radicand,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ROOT_W-1:0] o_root,
  output logic [ROOT_W:0]   o_rem,
  output logic [CNT_W-1:0]  o_inflight
);
  localparam int STAGES = ROOT_W;

  if ((RAD_W % 2) != 0 || RAD_W < 4) begin : g_bad_width
    $error("sqrt_pipe: RAD_W must be even and >= 4");
  end

  // Stage registers, index k = stage k
  logic [STAGES:1]             r_vld_pipe;
  logic [STAGES:1][ROOT_W-1:0] r_root;
  logic [STAGES:1][ROOT_W+1:0] r_rem;
  logic [STAGES:1][RAD_W-1:0]  r_rad;
  logic [CNT_W-1:0]            r_cnt;

  // w_cur_*[k] feeds stage k+1; w_nxt_*[k] is the next value of stage k
  logic [STAGES-1:0][ROOT_W-1:0] w_cur_root;
  logic [STAGES-1:0][ROOT_W+1:0] w_cur_rem;
  logic [STAGES-1:0][RAD_W-1:0]  w_cur_rad;
  logic [STAGES:1][ROOT_W-1:0]   w_nxt_root;
  logic [STAGES:1][ROOT_W+1:0]   w_nxt_rem;
  logic [STAGES:1][RAD_W-1:0]    w_nxt_rad;

  logic w_adv;
  logic w_acc;
  logic w_dlv;
  logic w_unused;

  assign w_adv = ~r_vld_pipe[STAGES] | i_ready;
  assign w_acc = i_valid & w_adv;
  assign w_dlv = r_vld_pipe[STAGES] & i_ready;

  // Stage sources: stage 1 starts from zero root/remainder. Non-accepted
  // input is zeroed so bubbles never carry X into the payload.
  always_comb begin
    w_cur_root    = '0;
    w_cur_rem     = '0;
    w_cur_rad     = '0;
    w_cur_rad[0]  = w_acc ? i_radicand : '0;
    for (int k = 1; k < STAGES; k++) begin
      w_cur_root[k] = r_root[k];
      w_cur_rem[k]  = r_rem[k];
      w_cur_rad[k]  = r_rad[k];
    end
  end

  for (genvar gk = 1; gk <= STAGES; gk++) begin : g_stage
    sqrt_stage #(.RAD_W(RAD_W), .ROOT_W(ROOT_W)) u_stage (
      .i_root (w_cur_root[gk-1]),
      .i_rem  (w_cur_rem[gk-1]),
      .i_rad  (w_cur_rad[gk-1]),
      .o_root (w_nxt_root[gk]),
      .o_rem  (w_nxt_rem[gk]),
      .o_rad  (w_nxt_rad[gk])
    );
  end

  // Pipeline shift: every stage moves together on adv, holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_root     <= '0;
      r_rem      <= '0;
      r_rad      <= '0;
    end else if (w_adv) begin
      r_vld_pipe[1] <= w_acc;
      for (int k = 2; k <= STAGES; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
      for (int k = 1; k <= STAGES; k++) begin
        r_root[k] <= w_nxt_root[k];
        r_rem[k]  <= w_nxt_rem[k];
        r_rad[k]  <= w_nxt_rad[k];
      end
    end
  end

  // In-flight count tracks valid stages, so it is bounded by STAGES
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      case ({w_acc, w_dlv})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_ready    = w_adv;
  assign o_valid    = r_vld_pipe[STAGES];
  assign o_root     = r_root[STAGES];
  assign o_rem      = r_rem[STAGES][ROOT_W:0];
  assign o_inflight = r_cnt;
  assign w_unused   = &{1'b0, r_rem[STAGES][ROOT_W+1], r_rad[STAGES]};
endmodule

// File: tb/tb_sqrt_pipe.sv
// Directed bench for sqrt_pipe (RAD_W = 10) plus a short random
// handshake run against a floor-sqrt model.
module tb_sqrt_pipe;
  localparam int RAD_W  = 10;
  localparam int ROOT_W = RAD_W / 2;
  localparam int CNT_W  = $clog2(ROOT_W + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_valid = 1'b0;
  logic              i_ready = 1'b1;
  logic [RAD_W-1:0]  i_radicand = '0;
  logic              o_ready;
  logic              o_valid;
  logic [ROOT_W-1:0] o_root;
  logic [ROOT_W:0]   o_rem;
  logic [CNT_W-1:0]  o_inflight;

  int n_chk  = 0;
  int n_pass = 0;
  int q_rad[$];
  int sent;
  int cyc;
  int r;

  always #5 clk = ~clk;

  sqrt_pipe #(.RAD_W(RAD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_radicand (i_radicand),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_root     (o_root),
    .o_rem      (o_rem),
    .o_inflight (o_inflight)
  );

  function automatic int isqrt(input int x);
    int k = 0;
    while ((k + 1) * (k + 1) <= x) k++;
    return k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic res(input string tag, input int v, input int rt, input int rm);
    chk({tag, "_v"},    32'(o_valid), 32'(v));
    chk({tag, "_root"}, 32'(o_root),  32'(rt));
    chk({tag, "_rem"},  32'(o_rem),   32'(rm));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    step; step;
    rst = 1'b0;
    #1;
    res("rst", 0, 0, 0);
    chk("rst_infl", 32'(o_inflight), 0);
    chk("rst_rdy",  32'(o_ready),    1);

    // streaming 0..4
    i_valid = 1'b1;
    i_radicand = 10'd0; step;
    i_radicand = 10'd1; step;
    i_radicand = 10'd2; step;
    i_radicand = 10'd3; step;
    chk("lat_early_v", 32'(o_valid), 0);
    i_radicand = 10'd4; step;
    res("s0", 1, 0, 0);
    chk("s_infl", 32'(o_inflight), 5);
    i_valid = 1'b0;
    step; res("s1", 1, 1, 0);
    step; res("s2", 1, 1, 1);
    step; res("s3", 1, 1, 2);
    step; res("s4", 1, 2, 0);
    step;
    chk("s_end_v",    32'(o_valid),    0);
    chk("s_end_infl", 32'(o_inflight), 0);

    // extremes
    i_valid = 1'b1;
    i_radicand = 10'd1023; step;
    i_radicand = 10'd1000; step;
    i_radicand = 10'd961;  step;
    i_radicand = 10'd999;  step;
    i_valid = 1'b0;
    step; res("x1023", 1, 31, 62);
    step; res("x1000", 1, 31, 39);
    step; res("x961",  1, 31, 0);
    step; res("x999",  1, 31, 38);
    step; chk("x_end_v", 32'(o_valid), 0);

    // backpressure
    i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_radicand = 10'(100 + k);
      step;
    end
    i_ready = 1'b0;
    i_radicand = 10'd500;
    #1;
    chk("bp_rdy",  32'(o_ready),    0);
    chk("bp_infl", 32'(o_inflight), 5);
    res("bp_hold0", 1, 10, 0);
    for (int k = 0; k < 7; k++) begin
      step;
      res("bp_hold", 1, 10, 0);
      chk("bp_hold_rdy",  32'(o_ready),    0);
      chk("bp_hold_infl", 32'(o_inflight), 5);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    step; res("bp_r1", 1, 10, 1);
    chk("bp_r1_infl", 32'(o_inflight), 4);
    step; res("bp_r2", 1, 10, 2);
    step; res("bp_r3", 1, 10, 3);
    step; res("bp_r4", 1, 10, 4);
    step;
    chk("bp_end_v",    32'(o_valid),    0);
    chk("bp_end_infl", 32'(o_inflight), 0);

    // bubbles
    i_valid = 1'b1; i_radicand = 10'd16; step;
    i_valid = 1'b0; step;
    i_valid = 1'b1; i_radicand = 10'd25; step;
    i_valid = 1'b0; step;
    step; res("bub16", 1, 4, 0);
    step; chk("bub_gap_v", 32'(o_valid), 0);
    step; res("bub25", 1, 5, 0);
    step;

    // reset mid-stream, with input offered during the reset cycle
    i_valid = 1'b1;
    i_radicand = 10'd50; step;
    i_radicand = 10'd60; step;
    i_radicand = 10'd70; step;
    chk("mr_infl3", 32'(o_inflight), 3);
    i_radicand = 10'd81;
    rst = 1'b1;
    step;
    rst = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("mr_v",    32'(o_valid),    0);
    chk("mr_infl", 32'(o_inflight), 0);
    chk("mr_rdy",  32'(o_ready),    1);
    for (int k = 0; k < 8; k++) begin
      step;
      chk("mr_stale_v", 32'(o_valid), 0);
    end
    chk("mr_end_infl", 32'(o_inflight), 0);

    // random operands with random stalls against the model
    sent = 0;
    cyc  = 0;
    while ((sent < 40 || q_rad.size() != 0) && cyc < 800) begin
      i_valid    = (sent < 40) && ($urandom_range(0, 3) != 0);
      i_radicand = 10'($urandom_range(0, 1023));
      i_ready    = ($urandom_range(0, 3) != 0);
      #1;
      if (o_valid && i_ready) begin
        if (q_rad.size() == 0) begin
          chk("rnd_spurious_v", 32'(o_valid), 0);
        end else begin
          r = isqrt(q_rad[0]);
          chk("rnd_root", 32'(o_root), 32'(r));
          chk("rnd_rem",  32'(o_rem),  32'(q_rad[0] - r * r));
          void'(q_rad.pop_front());
        end
      end
      if (i_valid && o_ready) begin
        q_rad.push_back(int'(i_radicand));
        sent++;
      end
      step;
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("rnd_drained", 32'(q_rad.size()), 0);
    chk("rnd_sent",    32'(sent),         40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
